// File: rtl/cc_gates_scan_ctrl.sv
// Scan sequencer: steps {a,b} through 00..11 on the gate block and returns the selected gate's truth table.
// Optional golden-table self-check is built when SC_GATESCAN_SELFCHECK_EN is defined.
module cc_gates_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       SC_GATESCAN_CLOCK_50,
   input  logic       SC_GATESCAN_RESET_InHigh,
   input  logic       SC_GATESCAN_start_In,
   input  logic [2:0] SC_GATESCAN_op_In,
   input  logic [7:0] SC_GATESCAN_gate_In,
   output logic       SC_GATESCAN_a_Out,
   output logic       SC_GATESCAN_b_Out,
   output logic       SC_GATESCAN_busy_Out,
   output logic       SC_GATESCAN_done_Out,
   output logic [3:0] SC_GATESCAN_table_Out,
   output logic       SC_GATESCAN_err_Out
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t           state_q;
   logic [2:0]       op_q;
   logic [1:0]       idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic             a_q, b_q, busy_q, done_q;
   logic [3:0]       table_q;

   logic       sel_c;
   logic [1:0] idx_nxt_c;
   logic [3:0] table_d;

   assign sel_c     = SC_GATESCAN_gate_In[op_q];
   assign idx_nxt_c = idx_q + 2'd1;

   // Current table with the sampled gate bit merged in at idx
   always_comb begin
      table_d        = table_q;
      table_d[idx_q] = sel_c;
   end

   always_ff @(posedge SC_GATESCAN_CLOCK_50 or posedge SC_GATESCAN_RESET_InHigh) begin
      if (SC_GATESCAN_RESET_InHigh) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         table_q <= 4'h0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (SC_GATESCAN_start_In) begin
                  op_q    <= SC_GATESCAN_op_In;
                  idx_q   <= 2'd0;
                  cnt_q   <= '0;
                  table_q <= 4'h0;
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= DRIVE;
               end
            end
            DRIVE: begin
               if (cnt_q == SETTLE_LAST) begin
                  cnt_q   <= '0;
                  state_q <= SAMPLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            SAMPLE: begin
               table_q <= table_d;
               if (idx_q == 2'd3) begin
                  a_q     <= 1'b0;
                  b_q     <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q   <= idx_nxt_c;
                  a_q     <= idx_nxt_c[1];
                  b_q     <= idx_nxt_c[0];
                  state_q <= DRIVE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SC_GATESCAN_SELFCHECK_EN
   logic err_q;

   function automatic logic [3:0] golden(input logic [2:0] op);
      case (op)
         3'd0, 3'd1:       golden = 4'b1000;
         3'd2:             golden = 4'b1110;
         3'd3, 3'd4, 3'd5: golden = 4'b0110;
         3'd6:             golden = 4'b0111;
         default:          golden = 4'b0001;
      endcase
   endfunction

   // Sticky mismatch flag, evaluated once the table is complete
   always_ff @(posedge SC_GATESCAN_CLOCK_50 or posedge SC_GATESCAN_RESET_InHigh) begin
      if (SC_GATESCAN_RESET_InHigh) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && SC_GATESCAN_start_In) begin
         err_q <= 1'b0;
      end else if (state_q == DONE) begin
         err_q <= (table_q != golden(op_q));
      end
   end

   assign SC_GATESCAN_err_Out = err_q;
`else
   assign SC_GATESCAN_err_Out = 1'b0;
`endif

   assign SC_GATESCAN_a_Out     = a_q;
   assign SC_GATESCAN_b_Out     = b_q;
   assign SC_GATESCAN_busy_Out  = busy_q;
   assign SC_GATESCAN_done_Out  = done_q;
   assign SC_GATESCAN_table_Out = table_q;

endmodule

// File: tb/tb_cc_gates_scan_ctrl.sv
// Bench for cc_gates_scan_ctrl: two instances (settle 1 and 3) share control inputs, each with its own gate model.
module tb_cc_gates_scan_ctrl;

`ifdef SC_GATESCAN_SELFCHECK_EN
   localparam bit SELFCHECK = 1'b1;
`else
   localparam bit SELFCHECK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op_i = 3'd0;
   logic [7:0] fz = 8'h00;

   logic       a1, b1, busy1, done1, err1;
   logic [3:0] tab1;
   logic       a3, b3, busy3, done3, err3;
   logic [3:0] tab3;
   logic [7:0] gate1, gate3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] gate_fn(input logic a, input logic b);
      return {~(a | b), ~(a & b), a ^ b, a ^ b, a ^ b, a | b, a & b, a & b};
   endfunction

   assign gate1 = gate_fn(a1, b1) & ~fz;
   assign gate3 = gate_fn(a3, b3) & ~fz;

   cc_gates_scan_ctrl #(.SETTLE_CYCLES(1)) dut1 (
      .SC_GATESCAN_CLOCK_50(clk), .SC_GATESCAN_RESET_InHigh(rst),
      .SC_GATESCAN_start_In(start), .SC_GATESCAN_op_In(op_i), .SC_GATESCAN_gate_In(gate1),
      .SC_GATESCAN_a_Out(a1), .SC_GATESCAN_b_Out(b1), .SC_GATESCAN_busy_Out(busy1),
      .SC_GATESCAN_done_Out(done1), .SC_GATESCAN_table_Out(tab1), .SC_GATESCAN_err_Out(err1));

   cc_gates_scan_ctrl #(.SETTLE_CYCLES(3)) dut3 (
      .SC_GATESCAN_CLOCK_50(clk), .SC_GATESCAN_RESET_InHigh(rst),
      .SC_GATESCAN_start_In(start), .SC_GATESCAN_op_In(op_i), .SC_GATESCAN_gate_In(gate3),
      .SC_GATESCAN_a_Out(a3), .SC_GATESCAN_b_Out(b3), .SC_GATESCAN_busy_Out(busy3),
      .SC_GATESCAN_done_Out(done3), .SC_GATESCAN_table_Out(tab3), .SC_GATESCAN_err_Out(err3));

   // Truth table from the gate definitions, using plain arithmetic on 0/1 operands
   function automatic logic [3:0] model_tt(input int op);
      logic [3:0] r;
      int a, b, v;
      r = 4'h0;
      for (int i = 0; i < 4; i++) begin
         a = i / 2;
         b = i % 2;
         case (op)
            0, 1:    v = a * b;
            2:       v = ((a + b) > 0) ? 1 : 0;
            3, 4, 5: v = ((a + b) == 1) ? 1 : 0;
            6:       v = 1 - a * b;
            default: v = ((a + b) == 0) ? 1 : 0;
         endcase
         r[i] = (v != 0);
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_dut(input string tag, input int t, input int per,
                          input logic a, input logic b, input logic busy, input logic done,
                          input logic [3:0] tab, input logic err,
                          input logic [3:0] exp_tab, input logic exp_err);
      int len, idx;
      len = 4 * per;
      if (t <= len) begin
         idx = (t - 1) / per;
         chk({tag, " ab"},   {a, b}, 32'(idx));
         chk({tag, " busy"}, busy, 1);
         chk({tag, " done"}, done, 0);
         chk({tag, " err"},  err, 0);
         if (t == 1) chk({tag, " tabclr"}, tab, 0);
      end else begin
         chk({tag, " ab"},   {a, b}, 0);
         chk({tag, " busy"}, busy, 0);
         chk({tag, " done"}, done, (t == len + 1) ? 1 : 0);
         chk({tag, " table"}, tab, exp_tab);
         chk({tag, " err"},  err, (t == len + 1) ? 1'b0 : exp_err);
      end
   endtask

   // One scan on both instances; pulse_t in 2..7 re-asserts start mid-scan (must be ignored)
   task automatic do_scan(input logic [2:0] op, input logic [7:0] fzm, input logic [3:0] exp_tab,
                          input int pulse_t, input string name);
      int n1, n3;
      logic exp_err;
      exp_err = SELFCHECK && (exp_tab != model_tt(int'(op)));
      n1 = 0;
      n3 = 0;
      @(negedge clk);
      fz    = fzm;
      op_i  = op;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_i  = 3'($urandom);
      for (int t = 1; t <= 18; t++) begin
         @(negedge clk);
         if (done1) n1++;
         if (done3) n3++;
         chk_dut({name, "/s1"}, t, 2, a1, b1, busy1, done1, tab1, err1, exp_tab, exp_err);
         chk_dut({name, "/s3"}, t, 4, a3, b3, busy3, done3, tab3, err3, exp_tab, exp_err);
         start = (t == pulse_t);
         op_i  = 3'($urandom);
      end
      start = 1'b0;
      chk({name, " s1 done count"}, n1, 1);
      chk({name, " s3 done count"}, n3, 1);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] fz;
      logic [3:0] exp_tab;
      int         pulse_t;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [2:0] rop;
      logic [7:0] rfz;
      vecs[0] = '{3'd0, 8'h00, 4'b1000, 0};
      vecs[1] = '{3'd2, 8'h00, 4'b1110, 0};
      vecs[2] = '{3'd5, 8'h00, 4'b0110, 0};
      vecs[3] = '{3'd7, 8'h00, 4'b0001, 0};
      vecs[4] = '{3'd3, 8'h00, 4'b0110, 3};
      vecs[5] = '{3'd6, 8'h40, 4'b0000, 0};
      vecs[6] = '{3'd6, 8'h00, 4'b0111, 0};

      #12;
      chk("reset a1",     a1, 0);
      chk("reset busy1",  busy1, 0);
      chk("reset done1",  done1, 0);
      chk("reset table1", tab1, 0);
      chk("reset err1",   err1, 0);
      chk("reset busy3",  busy3, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) do_scan(vecs[i].op, vecs[i].fz, vecs[i].exp_tab, vecs[i].pulse_t, $sformatf("vec%0d", i));

      // Reset in IDLE drops the held table
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("idle rst table1", tab1, 0);
      chk("idle rst table3", tab3, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-DRIVE returns everything to zero asynchronously
      @(negedge clk);
      op_i  = 3'd2;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-rst busy1", busy1, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid rst a1",    a1, 0);
      chk("mid rst b1",    b1, 0);
      chk("mid rst busy1", busy1, 0);
      chk("mid rst busy3", busy3, 0);
      chk("mid rst done1", done1, 0);
      chk("mid rst table1", tab1, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post rst idle busy1", busy1, 0);
         chk("post rst idle busy3", busy3, 0);
      end

      for (int n = 0; n < 20; n++) begin
         rop = 3'($urandom_range(0, 7));
         rfz = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         do_scan(rop, rfz, rfz[rop] ? 4'h0 : model_tt(int'(rop)),
                 int'($urandom_range(0, 7)), $sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
